// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, req/ack memory access, store lane formatting, load extension.
// Latency: accept -> mem_req next cycle; result valid the cycle after mem_ack (2 cycles minimum).
// Backpressure: one op in flight; in_ready low until the result is taken; result held until out_ready.
module lsu_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_func3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_misalign,
    output logic        out_err
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic          is_load_q, is_load_d;
    logic          is_store_q, is_store_d;
    logic [2:0]    func3_q, func3_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          misalign_q, misalign_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_illegal, in_misalign;
    logic [5:0]    lane_sh;
    logic [63:0]   rd_shift, rd_ext, wr_shift;
    logic [7:0]    wr_mask;
    logic          busy, resp;

    // Accept-time checks on the incoming op; func3[1:0] encodes access size for both loads and stores
    always_comb begin
        in_illegal  = (in_is_load && in_func3 == 3'b111) || (in_is_store && in_func3[2]);
        in_misalign = 1'b0;
        case (in_func3[1:0])
            2'b01:   in_misalign = in_addr[0];
            2'b10:   in_misalign = (in_addr[1:0] != 2'b00);
            2'b11:   in_misalign = (in_addr[2:0] != 3'b000);
            default: in_misalign = 1'b0;
        endcase
    end

    // Byte-lane shift, load extension and store mask from the captured op
    always_comb begin
        lane_sh  = {addr_q[2:0], 3'b000};
        rd_shift = mem_rdata >> lane_sh;
        wr_shift = wdata_q << lane_sh;
        case (func3_q)
            3'b000:  rd_ext = {{56{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  rd_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b100:  rd_ext = {56'd0, rd_shift[7:0]};
            3'b101:  rd_ext = {48'd0, rd_shift[15:0]};
            3'b110:  rd_ext = {32'd0, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
        case (func3_q[1:0])
            2'b00:   wr_mask = 8'h01 << addr_q[2:0];
            2'b01:   wr_mask = 8'h03 << addr_q[2:0];
            2'b10:   wr_mask = 8'h0F << addr_q[2:0];
            default: wr_mask = 8'hFF;
        endcase
    end

    // Next-state: accept decision, memory wait with watchdog, result hold
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        func3_d    = func3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    is_load_d  = in_is_load;
                    is_store_d = in_is_store;
                    func3_d    = in_func3;
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    rdata_d    = 64'd0;
                    misalign_d = 1'b0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    if (!in_is_load && !in_is_store) begin
                        state_d = RESP;
                    end else if (in_illegal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (in_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // ack takes precedence over a watchdog expiry in the same cycle
                if (mem_ack) begin
                    rdata_d = is_load_q ? rd_ext : 64'd0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = 64'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    rdata_d    = 64'd0;
                    misalign_d = 1'b0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-op registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            func3_q    <= 3'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            rdata_q    <= 64'd0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            func3_q    <= func3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are qualified by state and forced low while reset is held
    always_comb begin
        busy         = rst_n && (state_q == BUSY);
        resp         = rst_n && (state_q == RESP);
        in_ready     = rst_n && (state_q == IDLE);
        mem_req      = busy;
        mem_wen      = busy && is_store_q;
        mem_addr     = busy ? {addr_q[63:3], 3'b000} : 64'd0;
        mem_wdata    = (busy && is_store_q) ? wr_shift : 64'd0;
        mem_wmask    = (busy && is_store_q) ? wr_mask : 8'd0;
        out_valid    = resp;
        out_rdata    = resp ? rdata_q : 64'd0;
        out_misalign = resp && misalign_q;
        out_err      = resp && err_q;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_func3;
    logic [63:0] in_addr, in_wdata;
    logic        mem_req, mem_wen, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_ready, out_misalign, out_err;
    logic [63:0] out_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_func3(in_func3),
        .in_addr(in_addr), .in_wdata(in_wdata), .mem_req(mem_req), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_rdata(out_rdata), .out_misalign(out_misalign),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    // advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present an op for exactly one edge (in_ready is high in IDLE)
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st;
        in_func3 = f3; in_addr = a; in_wdata = wd;
        step();
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_func3 = 3'd0; in_addr = 64'd0; in_wdata = 64'd0;
        mem_ack = 1'b0; mem_rdata = 64'd0; out_ready = 1'b0;
        step(); step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outs: mem_req=%b out_valid=%b want 0 0", mem_req, out_valid); end
        rst_n = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_lb();
        issue(1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'd0);
        n_checks++; if (mem_req !== 1'b1 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL lb_req: req=%b wen=%b want 1 0", mem_req, mem_wen); end
        n_checks++; if (mem_addr !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL lb_addr: got %h want 80000000", mem_addr); end
        n_checks++; if (mem_wmask !== 8'h00) begin n_fail++; $display("FAIL lb_wmask: got %h want 00", mem_wmask); end
        step(); step();
        n_checks++; if (mem_req !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wait: req=%b valid=%b want 1 0", mem_req, out_valid); end
        mem_ack = 1'b1; mem_rdata = 64'h0000_0000_F000_0000;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_checks++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL lb_valid: valid=%b req=%b want 1 0", out_valid, mem_req); end
        n_checks++; if (out_rdata !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_fail++; $display("FAIL lb_rdata: got %h want fffffffffffffff0", out_rdata); end
        out_ready = 1'b1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_no_bypass: in_ready=%b want 0", in_ready); end
        step();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_exit: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_lhu_same_cycle();
        issue(1'b1, 1'b0, 3'b101, 64'h0000_0000_8000_0006, 64'd0);
        n_checks++; if (out_valid !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL lhu_t1: valid=%b req=%b want 0 1", out_valid, mem_req); end
        mem_ack = 1'b1; mem_rdata = 64'h8001_0000_0000_0000;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_checks++; if (out_valid !== 1'b1 || out_rdata !== 64'h8001) begin n_fail++; $display("FAIL lhu_result: valid=%b rdata=%h want 1 8001", out_valid, out_rdata); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_sh_backpressure();
        issue(1'b0, 1'b1, 3'b001, 64'h0000_0000_8000_0002, 64'h1234);
        n_checks++; if (mem_wen !== 1'b1 || mem_wmask !== 8'h0C) begin n_fail++; $display("FAIL sh_mask: wen=%b mask=%h want 1 0c", mem_wen, mem_wmask); end
        n_checks++; if (mem_wdata !== 64'h1234_0000) begin n_fail++; $display("FAIL sh_wdata: got %h want 12340000", mem_wdata); end
        step();
        n_checks++; if (mem_wdata !== 64'h1234_0000 || mem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL sh_hold: wdata=%h addr=%h want 12340000 80000000", mem_wdata, mem_addr); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rdata !== 64'd0 || out_err !== 1'b0) begin
                n_fail++; $display("FAIL sh_stall%0d: valid=%b in_ready=%b rdata=%h err=%b want 1 0 0 0", i, out_valid, in_ready, out_rdata, out_err);
            end
            step();
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL sh_exit: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_misalign_illegal();
        issue(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0006, 64'd0);
        n_checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_misalign !== 1'b1 || out_err !== 1'b0) begin n_fail++; $display("FAIL lw_misalign: req=%b valid=%b mis=%b err=%b want 0 1 1 0", mem_req, out_valid, out_misalign, out_err); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b111, 64'h0000_0000_8000_0008, 64'd0);
        n_checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || out_misalign !== 1'b0) begin n_fail++; $display("FAIL ld_illegal: req=%b valid=%b err=%b mis=%b want 0 1 1 0", mem_req, out_valid, out_err, out_misalign); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        issue(1'b0, 1'b0, 3'b000, 64'h0000_0000_8000_0001, 64'd0);
        n_checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b0 || out_misalign !== 1'b0 || out_rdata !== 64'd0) begin n_fail++; $display("FAIL nop_op: req=%b valid=%b err=%b mis=%b rdata=%h want 0 1 0 0 0", mem_req, out_valid, out_err, out_misalign, out_rdata); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        issue(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0010, 64'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL to_req%0d: got %b want 1", i, mem_req); end
            step();
        end
        n_checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 64'd0) begin n_fail++; $display("FAIL to_expire: req=%b valid=%b err=%b rdata=%h want 0 1 1 0", mem_req, out_valid, out_err, out_rdata); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0010, 64'd0);
        step(); step(); step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL to_4th_req: got %b want 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_rdata !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL to_ack_wins: valid=%b err=%b rdata=%h want 1 0 1122334455667788", out_valid, out_err, out_rdata); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        issue(1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0000, 64'd0);
        step();
        rst_n = 1'b0;
        step();
        n_checks++; if (mem_req !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy: req=%b in_ready=%b want 0 0", mem_req, in_ready); end
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hFF;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL late_ack: valid=%b req=%b in_ready=%b want 0 0 1", out_valid, mem_req, in_ready); end
        issue(1'b0, 1'b1, 3'b011, 64'h0000_0000_8000_0008, 64'hDEAD_BEEF_CAFE_F00D);
        n_checks++; if (mem_wmask !== 8'hFF || mem_wdata !== 64'hDEAD_BEEF_CAFE_F00D || mem_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL sd_fmt: mask=%h wdata=%h addr=%h want ff deadbeefcafef00d 80000008", mem_wmask, mem_wdata, mem_addr); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_rdata !== 64'd0) begin n_fail++; $display("FAIL sd_done: valid=%b err=%b rdata=%h want 1 0 0", out_valid, out_err, out_rdata); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_same_cycle();
        test_sh_backpressure();
        test_misalign_illegal();
        test_timeout();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencing unit for the NPC RV64 core; sits between EXU and the data-memory port.
- Accepts one memory op at a time: checks alignment, drives a variable-latency req/ack memory interface, and builds byte masks and shifted write data for stores.
- For loads, aligns and sign/zero-extends read data per func3 (lb/lh/lw/ld/lbu/lhu/lwu) before handing the result to WBU.
- Owns the memory-wait state machine plus a timeout watchdog.

Parameters:
TIMEOUT_CYC, 255, max cycles in BUSY without mem_ack before aborting with error (>=1)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  EXU op valid
in_ready  output  1  LSU can accept op
in_is_load  input  1  op is load
in_is_store  input  1  op is store (never both set with in_is_load)
in_func3  input  3  RV func3 of the op
in_addr  input  64  effective byte address
in_wdata  input  64  store data, LSB-aligned
mem_req  output  1  memory request, held until ack
mem_wen  output  1  1=write, 0=read; valid with mem_req
mem_addr  output  64  {in_addr[63:3],3'b000}
mem_wdata  output  64  store data shifted to byte lane
mem_wmask  output  8  byte-enable for writes, 0 on reads
mem_ack  input  1  memory done; mem_rdata valid same cycle
mem_rdata  input  64  aligned 8-byte read data
out_valid  output  1  result valid to WBU
out_ready  input  1  WBU accepts result
out_rdata  output  64  extended load data (0 for stores)
out_misalign  output  1  access misaligned, no memory access done
out_err  output  1  illegal func3 or timeout

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n): sampled only on the rising edge of clk.
- Reset state: with rst_n low at a clock edge, state=IDLE and the timeout counter clears. All outputs are 0, including in_ready, while rst_n is low.
- States: IDLE, BUSY, RESP.
- IDLE: in_ready=1. A handshake (in_valid&in_ready) captures is_load, is_store, func3, addr and wdata into registers.
- Accept decision, in priority order:
  - neither load nor store -> RESP, out_rdata=0, all flags 0.
  - illegal: load func3=111, or store func3>=100 -> RESP, out_err=1.
  - misaligned: h-type needs addr[0]=0, w-type addr[1:0]=0, d-type addr[2:0]=0; otherwise -> RESP, out_misalign=1. No mem_req is issued.
  - otherwise -> BUSY.
- BUSY:
  - mem_req=1 and mem_addr/mem_wen/mem_wdata/mem_wmask are held stable until mem_ack.
  - mem_ack=1 -> capture the extended data -> RESP.
  - Timeout counter counts BUSY cycles. When it reaches TIMEOUT_CYC without ack: drop mem_req, go to RESP with out_err=1 and out_rdata=0.
  - Ack in the same cycle the timeout fires: ack wins, no error.
- RESP:
  - out_valid=1; outputs stay stable until out_ready.
  - out_valid&out_ready -> IDLE. in_ready stays 0 that cycle (no bypass). Flags and counter clear on exit.
- Latency: op accepted at edge t -> mem_req high during cycle t+1. If ack is sampled at edge t+k, out_valid is high from cycle t+k+1. Minimum accept-to-result is 2 cycles with same-cycle ack.
- Store formatting, with off=addr[2:0]:
  - wdata = in_wdata << (8*off).
  - wmask: sb 8'h01<<off, sh 8'h03<<off, sw 8'h0F<<off, sd 8'hFF.
- Load formatting:
  - s = mem_rdata >> (8*off).
  - 000 sext s[7:0], 001 sext s[15:0], 010 sext s[31:0], 011 s.
  - 100/101/110: zero-extend 8/16/32 bits.
- Reset mid-transaction: mem_req drops on the cycle after the reset edge. A late mem_ack arriving in IDLE or RESP is ignored.
- mem_ack outside BUSY: no effect.

Test Plan:
- lb: addr=0x8000_0003, mem_rdata=0x0000_0000_F000_0000, ack after 3 cycles -> mem_addr=0x8000_0000, out_rdata=0xFFFF_FFFF_FFFF_FFF0, out_valid 1 cycle after ack.
- lhu: addr=0x...06, mem_rdata=0x8001_0000_0000_0000, same-cycle ack -> out_rdata=0x8001, 2-cycle latency.
- sh: addr=0x...02, in_wdata=0x1234 -> mem_wen=1, mem_wmask=0x0C, mem_wdata=0x1234_0000. Hold out_ready=0 for 3 cycles -> out_valid held and in_ready=0 throughout.
- lw at addr=0x...06 -> out_misalign=1, mem_req never asserted. ld func3=111 load -> out_err=1.
- TIMEOUT_CYC=4, no ack -> mem_req high 4 cycles, then out_err=1. Repeat with ack on the 4th cycle -> out_err=0 with valid data.
- Deassert rst_n during BUSY, then pulse mem_ack in IDLE -> mem_req=0 after the edge, no out_valid. Next op completes normally.
